// File: rtl/leaf_pkt_pkg.sv
`default_nettype none
// ============================================================================
// leaf_pkt_pkg : packet layout and port-map constants shared by the leaf tx/rx
// Revision     : 1.0
// ============================================================================
package leaf_pkt_pkg;

  localparam int unsigned DEF_PACKET_BITS   = 97;
  localparam int unsigned DEF_NUM_LEAF_BITS = 6;
  localparam int unsigned DEF_NUM_PORT_BITS = 4;
  localparam int unsigned DEF_PAYLOAD_BITS  =
    DEF_PACKET_BITS - 1 - DEF_NUM_LEAF_BITS - DEF_NUM_PORT_BITS;

  localparam int unsigned VLD_BIT  = DEF_PACKET_BITS - 1;
  localparam int unsigned LEAF_MSB = VLD_BIT - 1;
  localparam int unsigned LEAF_LSB = LEAF_MSB - DEF_NUM_LEAF_BITS + 1;
  localparam int unsigned PORT_MSB = LEAF_LSB - 1;
  localparam int unsigned PORT_LSB = PORT_MSB - DEF_NUM_PORT_BITS + 1;

  localparam int unsigned CTRL_PORT_LO  = 0;
  localparam int unsigned CTRL_PORT_HI  = 1;
  localparam int unsigned STRM_PORT_MIN = 2;
  localparam int unsigned STRM_PORT_MAX = 8;
  localparam int unsigned OUT_PORT_MIN  = 9;

  typedef struct packed {
    logic                          vld;
    logic [DEF_NUM_LEAF_BITS-1:0]  leaf;
    logic [DEF_NUM_PORT_BITS-1:0]  port;
    logic [DEF_PAYLOAD_BITS-1:0]   payload;
  } leaf_pkt_t;

  function automatic logic [DEF_PACKET_BITS-1:0] pkt_pack(
    input logic [DEF_NUM_LEAF_BITS-1:0] leaf,
    input logic [DEF_NUM_PORT_BITS-1:0] port,
    input logic [DEF_PAYLOAD_BITS-1:0]  payload
  );
    return {1'b1, leaf, port, payload};
  endfunction

  function automatic leaf_pkt_t pkt_unpack(input logic [DEF_PACKET_BITS-1:0] pkt);
    return leaf_pkt_t'(pkt);
  endfunction

  function automatic logic is_ctrl_port(input int unsigned port);
    return (port == CTRL_PORT_LO) || (port == CTRL_PORT_HI) || (port >= OUT_PORT_MIN);
  endfunction

  function automatic logic is_strm_port(input int unsigned port);
    return (port >= STRM_PORT_MIN) && (port <= STRM_PORT_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_tx_arb.sv
`default_nettype none
// ============================================================================
// leaf_tx_arb : control-priority arbiter with a stream starvation limit
// Revision    : 1.0
// ============================================================================
module leaf_tx_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_out_free,
  input  logic i_ctrl_valid,
  input  logic i_strm_valid,
  output logic o_grant_ctrl,
  output logic o_grant_strm
);

  logic [3:0] r_starve_cnt;
  logic       w_strm_turn;

  // Stream takes the slot when alone, or when control has had its quota.
  assign w_strm_turn  = i_strm_valid &&
                        (!i_ctrl_valid || (r_starve_cnt == 4'(STARVE_LIMIT)));
  assign o_grant_strm = i_out_free && w_strm_turn;
  assign o_grant_ctrl = i_out_free && i_ctrl_valid && !w_strm_turn;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (!i_strm_valid || o_grant_strm) begin
      r_starve_cnt <= 4'd0;
    end else if (o_grant_ctrl) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/leaf_tx_insert.sv
`default_nettype none
// ============================================================================
// leaf_tx_insert : merges control and stream packets into the registered BFT
//                  output, honouring resend and the leaf port map
// Revision       : 1.0
// ============================================================================
module leaf_tx_insert
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_LEAF_BITS = 6,
  parameter int NUM_PORT_BITS = 4,
  parameter int STARVE_LIMIT  = 4,
  parameter int PAYLOAD_BITS  = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ctrl_valid,
  output logic                     ctrl_ready,
  input  logic [NUM_LEAF_BITS-1:0] ctrl_leaf,
  input  logic [NUM_PORT_BITS-1:0] ctrl_port,
  input  logic [PAYLOAD_BITS-1:0]  ctrl_payload,
  input  logic                     strm_valid,
  output logic                     strm_ready,
  input  logic [NUM_LEAF_BITS-1:0] strm_leaf,
  input  logic [NUM_PORT_BITS-1:0] strm_port,
  input  logic [PAYLOAD_BITS-1:0]  strm_payload,
  input  logic                     resend,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  output logic                     err_illegal_port,
  output logic [15:0]              sent_count,
  output logic [15:0]              resend_count
);

  localparam int c_VLD = PACKET_BITS - 1;

  logic                   w_out_free;
  logic                   w_grant_ctrl;
  logic                   w_grant_strm;
  logic                   w_ctrl_hs;
  logic                   w_strm_hs;
  logic                   w_ctrl_legal;
  logic                   w_strm_legal;
  logic                   w_illegal;
  logic                   w_accept;
  logic [PACKET_BITS-1:0] w_dout_nxt;
  logic [PACKET_BITS-1:0] r_dout;
  logic                   r_err;
  logic [15:0]            r_sent;
  logic [15:0]            r_resend;

  // Free unless the packet currently presented is being rejected.
  assign w_out_free = !r_dout[c_VLD] || !resend;
  assign w_accept   = r_dout[c_VLD] && !resend;

  leaf_tx_arb #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .i_out_free   (w_out_free),
    .i_ctrl_valid (ctrl_valid),
    .i_strm_valid (strm_valid),
    .o_grant_ctrl (w_grant_ctrl),
    .o_grant_strm (w_grant_strm)
  );

  assign ctrl_ready = !reset && w_out_free && w_grant_ctrl;
  assign strm_ready = !reset && w_out_free && w_grant_strm;
  assign w_ctrl_hs  = ctrl_valid && ctrl_ready;
  assign w_strm_hs  = strm_valid && strm_ready;

  assign w_ctrl_legal = is_ctrl_port(32'(ctrl_port));
  assign w_strm_legal = is_strm_port(32'(strm_port));
  assign w_illegal    = (w_ctrl_hs && !w_ctrl_legal) || (w_strm_hs && !w_strm_legal);

  always_comb begin
    w_dout_nxt = '0;
    if (!w_out_free) begin
      w_dout_nxt = r_dout;
    end else if (w_ctrl_hs && w_ctrl_legal) begin
      w_dout_nxt = {1'b1, ctrl_leaf, ctrl_port, ctrl_payload};
    end else if (w_strm_hs && w_strm_legal) begin
      w_dout_nxt = {1'b1, strm_leaf, strm_port, strm_payload};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout   <= '0;
      r_err    <= 1'b0;
      r_sent   <= 16'd0;
      r_resend <= 16'd0;
    end else begin
      r_dout <= w_dout_nxt;
      r_err  <= w_illegal;
      if (w_accept) begin
        r_sent <= r_sent + 16'd1;
      end
      if (r_dout[c_VLD] && resend && (r_resend != 16'hFFFF)) begin
        r_resend <= r_resend + 16'd1;
      end
    end
  end

  assign dout_leaf_interface2bft = r_dout;
  assign err_illegal_port        = r_err;
  assign sent_count              = r_sent;
  assign resend_count            = r_resend;

endmodule
`default_nettype wire
